// File: rtl/text_font_fetcher.sv
// Text-mode cell sequencer: char code -> font row -> MSB-first pixels,
// with CPU glyph readback squeezed into idle font-ROM slots.
module text_font_fetcher #(
    parameter int COLS   = 32,
    parameter int ROWS   = 28,
    parameter int RAM_AW = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        hpos,
    input  logic [8:0]        vpos,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    output logic [10:0]       font_addr,
    input  logic [7:0]        font_data,
    input  logic              cpu_req,
    input  logic [10:0]       cpu_addr,
    output logic              cpu_ack,
    output logic [7:0]        cpu_data,
    output logic              pixel
);

    typedef enum logic {
        C_IDLE,
        C_BUSY
    } cstate_t;

    logic [5:0]        col;
    logic [5:0]        row;
    logic [2:0]        ph;
    logic [2:0]        line;
    logic              active;
    logic [RAM_AW-1:0] ram_idx;

    logic [7:0]        char_q;
    logic [7:0]        next_q;
    logic [7:0]        shift_q;

    logic              f_ram;
    logic              f_char;
    logic              f_font;
    logic              f_next;

    cstate_t           cstate;
    cstate_t           cnext;
    logic              issue;
    logic              grant;

    assign col     = hpos[8:3];
    assign row     = vpos[8:3];
    assign ph      = hpos[2:0];
    assign line    = vpos[2:0];
    assign active  = (int'(col) < COLS) && (int'(row) < ROWS);
    assign ram_idx = RAM_AW'(int'(row) * COLS + int'(col));

    always_comb begin
        f_ram  = 1'b0;
        f_char = 1'b0;
        f_font = 1'b0;
        f_next = 1'b0;
        if (active) begin
            case (ph)
                3'd0:    f_ram  = 1'b1;
                3'd1:    f_char = 1'b1;
                3'd2:    f_font = 1'b1;
                3'd3:    f_next = 1'b1;
                default: ;
            endcase
        end
    end

    // While a cell is active the CPU only gets the ph4 slot, so video never waits.
    always_comb begin
        cnext = cstate;
        issue = 1'b0;
        grant = 1'b0;
        unique case (cstate)
            C_IDLE: begin
                if (cpu_req && (!active || ph == 3'd4)) begin
                    issue = 1'b1;
                    cnext = C_BUSY;
                end
            end
            C_BUSY: begin
                grant = cpu_req;
                cnext = C_IDLE;
            end
            default: cnext = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cstate <= C_IDLE;
        end else begin
            cstate <= cnext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr  <= '0;
            font_addr <= '0;
            cpu_ack   <= 1'b0;
            cpu_data  <= '0;
            pixel     <= 1'b0;
            char_q    <= '0;
            next_q    <= '0;
            shift_q   <= '0;
        end else begin
            cpu_ack <= grant;
            if (grant) begin
                cpu_data <= font_data;
            end
            if (f_ram) begin
                ram_addr <= ram_idx;
            end
            if (f_char) begin
                char_q <= ram_data;
            end
            if (f_next) begin
                next_q <= font_data;
            end
            unique case (1'b1)
                issue:   font_addr <= cpu_addr;
                f_font:  font_addr <= {char_q, line};
                default: ;
            endcase
            if (ph == 3'd7) begin
                shift_q <= active ? next_q : 8'h00;
            end else begin
                shift_q <= {shift_q[6:0], 1'b0};
            end
            pixel <= shift_q[7];
        end
    end

endmodule
